// File: rtl/lockin_pkg.sv
// Shared types and constants for the lock-in run controller.
package lockin_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_NCYC   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_SCNT   = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;
    localparam int STAT_STIGN   = 3;
    localparam int STAT_OVF     = 4;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_IRQM  = 2;

    function automatic logic is_busy(input state_t s);
        return (s == CLEAR) || (s == ARM) || (s == RUN);
    endfunction

endpackage

// File: rtl/lockin_sat_counter.sv
// Saturating up-counter with synchronous clear; o_ovf flags an increment lost at all-ones.
module lockin_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_ovf
);
    logic [W-1:0] r_cnt;
    logic         w_full;

    assign w_full = &r_cnt;
    assign o_cnt  = r_cnt;
    assign o_ovf  = i_en & w_full & ~i_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && !w_full)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/lockin_run_controller.sv
// Lock-in acquisition run sequencer with an Avalon-MM register slave.
// Optional LOCKIN_RUN_IRQ_EN adds an irq output and a CTRL IRQ_MASK bit.
module lockin_run_controller
    import lockin_pkg::*;
#(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] DEFAULT_N = 32'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        ref_sync,
    input  logic        sample_valid,
    output logic        acc_clear,
    output logic        acq_enable,
    output logic        finalizacion
`ifdef LOCKIN_RUN_IRQ_EN
    ,
    output logic        irq
`endif
);
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_n;
    logic [CNT_W-1:0]   r_pcnt;
    logic [CNT_W-1:0]   w_scnt;
    logic               w_sovf;
    logic               r_aborted, r_stign, r_ovf;
    logic               w_busy, w_ctrl_wr, w_start, w_abort, w_last;
    logic [31:0]        w_status;

    assign w_busy    = is_busy(r_state);
    assign w_ctrl_wr = write && (address == ADDR_CTRL);
    assign w_abort   = w_ctrl_wr && writedata[CTRL_ABORT];
    assign w_start   = w_ctrl_wr && writedata[CTRL_START] && !w_abort;
    assign w_last    = (r_pcnt == r_n - 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start) w_next = CLEAR;
                CLEAR:   w_next = ARM;
                ARM:     if (ref_sync) w_next = RUN;
                RUN:     if (ref_sync && w_last) w_next = DONE;
                DONE:    if (w_start) w_next = CLEAR;
                default: w_next = IDLE;
            endcase
        end
    end

    // Datapath controls are registered off the next state so they line up with state entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_clear    <= 1'b0;
            acq_enable   <= 1'b0;
            finalizacion <= 1'b0;
        end else begin
            acc_clear    <= (w_next == CLEAR);
            acq_enable   <= (w_next == RUN);
            finalizacion <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pcnt <= '0;
        else if (r_state == CLEAR)
            r_pcnt <= '0;
        else if (r_state == RUN && ref_sync && !w_last && !w_abort)
            r_pcnt <= r_pcnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_n <= DEFAULT_N[CNT_W-1:0];
        else if (write && address == ADDR_NCYC && !w_busy)
            r_n <= (writedata[CNT_W-1:0] == '0) ? CNT_W'(1) : writedata[CNT_W-1:0];
    end

    lockin_sat_counter #(.W(CNT_W)) u_scnt (
        .clk   (clk),
        .rst   (reset),
        .i_clr (r_state == CLEAR),
        .i_en  ((r_state == RUN) && acq_enable && sample_valid),
        .o_cnt (w_scnt),
        .o_ovf (w_sovf)
    );

    // Sticky bits: a new event wins over a same-cycle W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aborted <= 1'b0;
            r_stign   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (write && address == ADDR_STATUS) begin
                if (writedata[STAT_ABORTED]) r_aborted <= 1'b0;
                if (writedata[STAT_STIGN])   r_stign   <= 1'b0;
                if (writedata[STAT_OVF])     r_ovf     <= 1'b0;
            end
            if (w_abort && w_busy) r_aborted <= 1'b1;
            if (w_start && w_busy) r_stign   <= 1'b1;
            if (w_sovf)            r_ovf     <= 1'b1;
        end
    end

    always_comb begin
        w_status               = '0;
        w_status[STAT_BUSY]    = w_busy;
        w_status[STAT_DONE]    = (r_state == DONE);
        w_status[STAT_ABORTED] = r_aborted;
        w_status[STAT_STIGN]   = r_stign;
        w_status[STAT_OVF]     = r_ovf;
    end

`ifdef LOCKIN_RUN_IRQ_EN
    logic r_irq_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_irq_mask <= 1'b0;
        else if (w_ctrl_wr)
            r_irq_mask <= writedata[CTRL_IRQM];
    end

    assign irq = r_irq_mask && (r_state == DONE);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            case (address)
`ifdef LOCKIN_RUN_IRQ_EN
                ADDR_CTRL:   readdata <= 32'(r_irq_mask) << CTRL_IRQM;
`else
                ADDR_CTRL:   readdata <= '0;
`endif
                ADDR_NCYC:   readdata <= 32'(r_n);
                ADDR_STATUS: readdata <= w_status;
                ADDR_SCNT:   readdata <= 32'(w_scnt);
                default:     readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lockin_run_controller.sv
// Directed self-checking bench for lockin_run_controller (build with LOCKIN_RUN_IRQ_EN to cover irq).
module tb_lockin_run_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        ref_sync = 1'b0;
    logic        sample_valid = 1'b0;
    logic        acc_clear, acq_enable, finalizacion;
`ifdef LOCKIN_RUN_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int clr_cnt = 0;
    int acq_cnt = 0;

    lockin_run_controller dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .write        (write),
        .writedata    (writedata),
        .read         (read),
        .readdata     (readdata),
        .ref_sync     (ref_sync),
        .sample_valid (sample_valid),
        .acc_clear    (acc_clear),
        .acq_enable   (acq_enable),
        .finalizacion (finalizacion)
`ifdef LOCKIN_RUN_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    // ref_sync every 10 cycles, sample_valid every 2, driven on the falling edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        ref_sync     <= (cyc % 10 == 0);
        sample_valid <= (cyc % 2 == 0);
    end

    always @(negedge clk) begin
        if (acc_clear)  clr_cnt <= clr_cnt + 1;
        if (acq_enable) acq_cnt <= acq_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0; writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_fin(input string name);
        for (int i = 0; i < 200 && !finalizacion; i++) @(negedge clk);
        check(name, {31'b0, finalizacion}, 32'd1);
    endtask

    task automatic wait_acq(input string name);
        for (int i = 0; i < 200 && !acq_enable; i++) @(negedge clk);
        check(name, {31'b0, acq_enable}, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t tbl[4];

    initial begin
        int c0, a0;
        tbl[0] = '{"rst_ctrl",   2'd0, 32'd0};
        tbl[1] = '{"rst_ncyc",   2'd1, 32'd1024};
        tbl[2] = '{"rst_status", 2'd2, 32'd0};
        tbl[3] = '{"rst_scnt",   2'd3, 32'd0};

        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        reset = 1'b0;
        check("rst_fin", {31'b0, finalizacion}, 32'd0);
        check("rst_acq", {31'b0, acq_enable}, 32'd0);
        check("rst_clr", {31'b0, acc_clear}, 32'd0);
        for (int i = 0; i < 4; i++) rd_check(tbl[i].name, tbl[i].addr, tbl[i].exp);

        // N=3 run: 3 whole periods of 10 cycles, one sample every 2 cycles
        bus_write(2'd1, 32'd3);
        c0 = clr_cnt; a0 = acq_cnt;
        bus_write(2'd0, 32'h1);
        wait_fin("run3_fin");
        @(negedge clk);
        check("run3_clr_pulses", clr_cnt - c0, 32'd1);
        check("run3_acq_cycles", acq_cnt - a0, 32'd30);
        check("run3_acq_low", {31'b0, acq_enable}, 32'd0);
        rd_check("run3_status", 2'd2, 32'h02);
        rd_check("run3_scnt", 2'd3, 32'd15);

        // N=0 is stored as 1: run ends on the first ref_sync in RUN
        bus_write(2'd1, 32'd0);
        rd_check("n0_ncyc", 2'd1, 32'd1);
        a0 = acq_cnt;
        bus_write(2'd0, 32'h1);
        wait_fin("n1_fin");
        @(negedge clk);
        check("n1_acq_cycles", acq_cnt - a0, 32'd10);
        rd_check("n1_scnt", 2'd3, 32'd5);

        // START while running is ignored and flagged; N write while busy is dropped
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'h1);
        wait_acq("ign_acq");
        bus_write(2'd0, 32'h1);
        bus_write(2'd1, 32'd7);
        rd_check("ign_status_run", 2'd2, 32'h09);
        rd_check("ign_ncyc", 2'd1, 32'd3);
        wait_fin("ign_fin");
        rd_check("ign_status_done", 2'd2, 32'h0A);
        bus_write(2'd2, 32'h08);
        rd_check("ign_w1c", 2'd2, 32'h02);

        // START+ABORT together mid-run: ABORT wins
        bus_write(2'd0, 32'h1);
        wait_acq("abt_acq");
        repeat (3) @(negedge clk);
        bus_write(2'd0, 32'h3);
        check("abt_acq_low", {31'b0, acq_enable}, 32'd0);
        check("abt_fin_low", {31'b0, finalizacion}, 32'd0);
        check("abt_clr_low", {31'b0, acc_clear}, 32'd0);
        rd_check("abt_status", 2'd2, 32'h04);
        bus_write(2'd2, 32'h04);
        bus_write(2'd0, 32'h2);
        rd_check("abt_idle_status", 2'd2, 32'h00);

        // Asynchronous reset mid-run
        bus_write(2'd0, 32'h1);
        wait_acq("rst_run_acq");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_acq", {31'b0, acq_enable}, 32'd0);
        check("arst_fin", {31'b0, finalizacion}, 32'd0);
        check("arst_clr", {31'b0, acc_clear}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_check("arst_ncyc", 2'd1, 32'd1024);
        rd_check("arst_status", 2'd2, 32'h00);

`ifdef LOCKIN_RUN_IRQ_EN
        bus_write(2'd0, 32'h4);
        rd_check("irq_mask_rd", 2'd0, 32'h4);
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h5);
        check("irq_low_run", {31'b0, irq}, 32'd0);
        wait_fin("irq_fin");
        check("irq_high", {31'b0, irq}, 32'd1);
        bus_write(2'd0, 32'h5);
        check("irq_cleared", {31'b0, irq}, 32'd0);
`else
        rd_check("ctrl_rd_zero", 2'd0, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
